cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//   Host-side initiator for the control unit's START/RDY handshake.
//   - Brings the core to READY after reset.
//   - Launches a run with a one-cycle START and counts execution cycles.
//   - Detects completion when RDY returns high.
//   - Aborts runaway programs on timeout or host request, using the core's sync reset.
// PARAMETERS
//   CYCLE_W  16  width of cycle counter and MAX_CYCLES
// PORTS
//   CLK         in   1        clock, rising edge
//   RESET_N     in   1        asynchronous, active-low reset
//   RUN         in   1        host run request; sampled in IDLE only
//   ABORT       in   1        host abort request; sampled in RUNNING only
//   MAX_CYCLES  in   CYCLE_W  timeout limit; 0 = no limit; sampled every cycle in RUNNING
//   BUSY        out  1        high in every state except IDLE
//   DONE        out  1        one-cycle pulse when a run ends, by any cause
//   RESULT      out  2        00 = ok, 01 = timeout, 10 = aborted; held until next launch
//   CYCLES      out  CYCLE_W  count of cycles with CPU_RDY=0 in the current/last run
//   CPU_START   out  1        drives control unit START
//   CPU_RESET   out  1        drives control unit RESET (sync, active high)
//   CPU_RDY     in   1        from control unit RDY
// BEHAVIOUR
//   RESET_N=0 (async): state=INIT, CPU_RESET=1, CPU_START=0, BUSY=1,
//     DONE=0, RESULT=00, CYCLES=0.
//   States: INIT, IDLE, LAUNCH, RUNNING, KILL. Encoding is free; no unreachable lockup.
//   CPU_START, CPU_RESET and BUSY decode from the state register only; no input-to-output paths.
//   DONE, RESULT and CYCLES are registers.
//   INIT: CPU_RESET=1 for exactly one cycle -> IDLE.
//   IDLE:
//     - RUN=1 && CPU_RDY=1 -> LAUNCH; CYCLES<=0; RESULT<=00.
//     - RUN while CPU_RDY=0 is ignored; stay IDLE.
//   LAUNCH: CPU_START=1 for exactly one cycle -> RUNNING.
//     The core leaves READY on this edge, so CPU_RDY is 0 from the first RUNNING cycle.
//   RUNNING, checks in priority order each cycle:
//     1. CPU_RDY=1: -> IDLE; DONE<=1 next cycle; RESULT stays 00; CYCLES frozen.
//     2. ABORT=1: -> KILL; RESULT<=10.
//     3. MAX_CYCLES!=0 && CYCLES==MAX_CYCLES: -> KILL; RESULT<=01.
//     4. Otherwise: CYCLES<=CYCLES+1, saturating at all-ones (no wrap).
//   KILL: CPU_RESET=1 for one cycle; DONE<=1 next cycle; -> IDLE.
//     The core is back in READY (CPU_RDY=1) on the following cycle.
//   DONE is high for exactly one cycle per run; 0 otherwise.
//   Ignored inputs:
//     - RUN in any state other than IDLE is ignored; requests are not queued.
//     - ABORT outside RUNNING is ignored.
//   Completion coincident with ABORT or timeout counts as ok (priority 1 wins).
//   Minimum run (program = STOP): CPU_RDY low for 2 cycles -> CYCLES=2, RESULT=00.
//   Latency: RUN accepted -> DONE = CYCLES + 2 clock cycles.
//   Timeout: with MAX_CYCLES=N, a run lasting more than N cycles is killed with CYCLES=N.
//   RESET_N asserted mid-run returns to INIT, which re-resets the core.
// TESTING
//   1. Reset release: CPU_RESET=1 for one cycle, then IDLE with BUSY=0, DONE=0, RESULT=00.
//   2. Program STOP, RUN pulse: CPU_START one cycle -> DONE one cycle later;
//      CYCLES=2, RESULT=00.
//   3. Program LDI;STOP, MAX_CYCLES=0: CYCLES=4, RESULT=00.
//      RUN held high during the run does not re-launch.
//   4. Infinite loop (JMP to self), MAX_CYCLES=10:
//      CPU_RESET pulse after 10 counted cycles; CYCLES=10, RESULT=01, DONE pulse.
//   5. ABORT=1 at 3rd RUNNING cycle: KILL, RESULT=10, CYCLES=2.
//      ABORT in the same cycle CPU_RDY rises: RESULT=00.
//   6. RESET_N low during RUNNING: outputs return to reset values immediately.
//      A fresh run afterwards completes normally.

Source files
------------

// File: rtl/cpu_run_controller.sv
// Host-side run controller for the control unit's START/RDY handshake:
// resets the core, launches runs, counts execution cycles and kills runaways.
module cpu_run_controller #(
    parameter int CYCLE_W = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               RUN,
    input  logic               ABORT,
    input  logic [CYCLE_W-1:0] MAX_CYCLES,
    output logic               BUSY,
    output logic               DONE,
    output logic [1:0]         RESULT,
    output logic [CYCLE_W-1:0] CYCLES,
    output logic               CPU_START,
    output logic               CPU_RESET,
    input  logic               CPU_RDY,
    output logic [2:0]         DBG_STATE
);

    // Handshake: the core accepts START only while RDY=1 and drops RDY on that
    // same edge; RDY returning high marks completion. RESET is a synchronous
    // one-cycle pulse after which the core reports RDY=1 on the next cycle.
    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_LAUNCH  = 3'd2;
    localparam logic [2:0] ST_RUNNING = 3'd3;
    localparam logic [2:0] ST_KILL    = 3'd4;

    localparam logic [1:0] RES_OK      = 2'b00;
    localparam logic [1:0] RES_TIMEOUT = 2'b01;
    localparam logic [1:0] RES_ABORT   = 2'b10;

    logic [2:0]         state_q, state_d;
    logic               done_q, done_d;
    logic [1:0]         result_q, result_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d;

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        cycles_d = cycles_q;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (RUN && CPU_RDY) begin
                    state_d  = ST_LAUNCH;
                    cycles_d = '0;
                    result_d = RES_OK;
                end
            end
            ST_LAUNCH: state_d = ST_RUNNING;
            ST_RUNNING: begin
                // Completion outranks abort and timeout when they coincide.
                if (CPU_RDY) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (ABORT) begin
                    state_d  = ST_KILL;
                    result_d = RES_ABORT;
                end else if ((MAX_CYCLES != '0) && (cycles_q == MAX_CYCLES)) begin
                    state_d  = ST_KILL;
                    result_d = RES_TIMEOUT;
                end else if (cycles_q != '1) begin
                    cycles_d = cycles_q + CYCLE_W'(1);
                end
            end
            ST_KILL: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_INIT;
            done_q   <= 1'b0;
            result_q <= RES_OK;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            cycles_q <= cycles_d;
        end
    end

    assign CPU_RESET = (state_q == ST_INIT) || (state_q == ST_KILL);
    assign CPU_START = (state_q == ST_LAUNCH);
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign CYCLES    = cycles_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: behavioural control-unit model, directed runs,
// and a DONE-triggered scoreboard comparing RESULT/CYCLES against expectations.
module tb_cpu_run_controller;

    localparam int CW = 16;
    localparam int W  = 18;

    logic          clk = 1'b0;
    logic          rst_n, run, abort;
    logic [CW-1:0] max_cycles;
    logic          busy, done, cpu_start, cpu_reset, cpu_rdy;
    logic [1:0]    result;
    logic [CW-1:0] cycles;
    logic [2:0]    dbg_state;

    cpu_run_controller #(.CYCLE_W(CW)) dut (
        .CLK(clk), .RESET_N(rst_n), .RUN(run), .ABORT(abort),
        .MAX_CYCLES(max_cycles), .BUSY(busy), .DONE(done), .RESULT(result),
        .CYCLES(cycles), .CPU_START(cpu_start), .CPU_RESET(cpu_reset),
        .CPU_RDY(cpu_rdy), .DBG_STATE(dbg_state)
    );

    always #5 clk = ~clk;

    // Control unit model: RDY low for prog_len cycles after START, forever if prog_inf.
    int   prog_len  = 2;
    bit   prog_inf  = 1'b0;
    bit   rdy_block = 1'b0;
    logic core_rdy  = 1'b0;
    int   core_rem  = 0;

    always @(posedge clk) begin
        if (cpu_reset) begin
            core_rdy <= 1'b1;
            core_rem <= 0;
        end else if (cpu_start && core_rdy) begin
            core_rdy <= 1'b0;
            core_rem <= prog_len - 1;
        end else if (!core_rdy && !prog_inf) begin
            if (core_rem == 0) core_rdy <= 1'b1;
            else core_rem <= core_rem - 1;
        end
    end
    assign cpu_rdy = core_rdy & ~rdy_block;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every DONE pulse pops one expected {RESULT, CYCLES}.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [W-1:0] e;
            chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", {30'd0, result}, {30'd0, e[17:16]});
                chk("cycles", {16'd0, cycles}, {16'd0, e[15:0]});
            end
        end
        done_prev <= done;
    end

    task automatic run_prog(input int len, input bit inf, input logic [CW-1:0] maxc,
                            input int abort_at, input bit hold, input logic [1:0] er,
                            input logic [CW-1:0] ec, input string tag);
        int lat = -1;
        int starts = 0;
        int exp_lat;
        prog_len   = len;
        prog_inf   = inf;
        max_cycles = maxc;
        exp_q.push_back({er, ec});
        @(posedge clk); #1;
        run = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (!hold) run = 1'b0;
            abort = (k == abort_at);
            @(negedge clk);
            if (cpu_start) starts++;
            if (done) begin
                lat = k;
                run = 1'b0;
                break;
            end
        end
        abort = 1'b0;
        run   = 1'b0;
        exp_lat = (er == 2'b00) ? 32'(ec) + 2 : 32'(ec) + 3;
        if (lat < 0) begin
            chk({tag, "_done_seen"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_start_pulses"}, 32'(starts), 32'd1);
            chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        end
        prog_inf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int rc;
        int st;
        rst_n = 1'b0; run = 1'b0; abort = 1'b0; max_cycles = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {30'd0, result}, 32'd0);
        chk("rst_cycles", {16'd0, cycles}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        rc = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_reset) rc++;
        end
        chk("init_reset_pulse_len", 32'(rc), 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_result", {30'd0, result}, 32'd0);
        chk("idle_state", {29'd0, dbg_state}, 32'd1);

        // RUN while the core is not ready must not launch.
        rdy_block = 1'b1;
        @(posedge clk); #1;
        run = 1'b1;
        st = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_start) st++;
        end
        run = 1'b0;
        rdy_block = 1'b0;
        chk("run_not_ready_starts", 32'(st), 32'd0);
        chk("run_not_ready_busy", {31'd0, busy}, 32'd0);

        // ABORT in IDLE is ignored.
        @(posedge clk); #1;
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);

        run_prog(2,  1'b0, 16'd0,  -1, 1'b0, 2'b00, 16'd2,  "stop");
        run_prog(4,  1'b0, 16'd0,  -1, 1'b1, 2'b00, 16'd4,  "ldi_stop_hold");
        run_prog(0,  1'b1, 16'd10, -1, 1'b0, 2'b01, 16'd10, "loop_timeout");
        run_prog(10, 1'b0, 16'd10, -1, 1'b0, 2'b00, 16'd10, "len_eq_max");
        run_prog(11, 1'b0, 16'd10, -1, 1'b0, 2'b01, 16'd10, "len_gt_max");
        run_prog(10, 1'b0, 16'd0,  3,  1'b0, 2'b10, 16'd2,  "abort");
        run_prog(2,  1'b0, 16'd0,  3,  1'b0, 2'b00, 16'd2,  "abort_vs_done");

        // Reset in the middle of an endless run.
        prog_inf = 1'b1;
        max_cycles = '0;
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("midrst_cpu_start", {31'd0, cpu_start}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", {30'd0, result}, 32'd0);
        chk("midrst_cycles", {16'd0, cycles}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        prog_inf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_prog(2, 1'b0, 16'd0, -1, 1'b0, 2'b00, 16'd2, "after_reset");

        @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
